sd_tx_prefetch: RTL

SD_TX_PREFETCH -- requirements
Module: sd_tx_prefetch

---
 rtl/sd_tx_prefetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sd_tx_prefetch.sv
// Wishbone read prefetcher feeding a first-word-fall-through FIFO for an SD transmit path.
// Optional macro SD_TX_PREFETCH_BURST_EN enables incrementing bursts; otherwise each access is a classic single cycle.
module sd_tx_prefetch #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 16,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [AW-1:0]            m_wb_adr_o,
  output logic                     m_wb_we_o,
  input  logic [DW-1:0]            m_wb_dat_i,
  output logic                     m_wb_cyc_o,
  output logic                     m_wb_stb_o,
  input  logic                     m_wb_ack_i,
  output logic [2:0]               m_wb_cti_o,
  output logic [1:0]               m_wb_bte_o,
  input  logic                     en,
  input  logic [AW-1:0]            adr,
  input  logic                     rd,
  output logic [DW-1:0]            dat_o,
  output logic                     empty,
  output logic                     fe,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
`ifdef SD_TX_PREFETCH_BURST_EN
  localparam int EB = BURST;
`else
  localparam int EB = 1;
`endif
  localparam int BW = (EB > 1) ? $clog2(EB) : 1;
  localparam logic [AW-1:0] STEP   = AW'(DW / 8);
  localparam logic [LW-1:0] EBL    = LW'(EB);
  localparam logic [LW-1:0] DEPTHL = LW'(DEPTH);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_ptr;
  logic [BW-1:0]   r_beat;
  logic            r_arm;
  logic [PW-1:0]   r_wp, r_rp;
  logic [LW-1:0]   r_level;
  logic [DW-1:0]   r_mem [DEPTH];
  logic            w_bus, w_wr, w_rd, w_last, w_start;

  assign w_bus   = (r_state == S_BUS);
  assign w_wr    = w_bus && m_wb_ack_i && en;
  assign w_rd    = rd && (r_level != '0) && en;
  assign w_last  = (r_beat == BW'(EB - 1));
  // r_arm delays the first burst by one edge after en rises, so the pointer is stable.
  assign w_start = en && r_arm && ((DEPTHL - r_level) >= EBL);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_BUS;
      S_BUS:  if (w_wr && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!en) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr  <= '0;
      r_beat <= '0;
      r_arm  <= 1'b0;
    end else if (!en) begin
      r_ptr  <= adr;
      r_beat <= '0;
      r_arm  <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      if (w_wr) begin
        r_ptr  <= r_ptr + STEP;
        r_beat <= w_last ? '0 : r_beat + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else if (!en) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + PW'(1);
      if (w_rd) r_rp <= r_rp + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; dat_o is gated so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= m_wb_dat_i;
  end

  assign m_wb_cyc_o = w_bus;
  assign m_wb_stb_o = w_bus;
  assign m_wb_we_o  = 1'b0;
  assign m_wb_bte_o = 2'b00;
  assign m_wb_adr_o = w_bus ? r_ptr : '0;
`ifdef SD_TX_PREFETCH_BURST_EN
  assign m_wb_cti_o = !w_bus ? 3'b000 : (w_last ? 3'b111 : 3'b010);
`else
  assign m_wb_cti_o = 3'b000;
`endif

  assign level = r_level;
  assign empty = (r_level == '0);
  assign fe    = (r_level == DEPTHL);
  assign dat_o = (rst && !empty) ? r_mem[r_rp] : '0;

endmodule
